// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
//   Loads operands A/B and carry-in on accept, then adds one bit per clock
//   (LSB first) for WIDTH cycles, pulses done for one cycle, and returns to IDLE.
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the registered signed-overflow
// output ovf.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   begin an addition (sampled only in IDLE)
//   a, b   in   WIDTH-bit operands, captured at accept
//   cin    in   carry-in, captured at accept
//   sum    out  registered result, held until the next accept
//   cout   out  registered carry out of the MSB
//   busy   out  high while shifting
//   done   out  one-cycle pulse when the result is valid
//   ovf    out  (SERIAL_ADD_OVF_EN only) two's-complement overflow
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADD_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic w_s;
  logic w_co;
  logic w_last;

  always_comb begin
    w_s    = r_a[0] ^ r_b[0] ^ r_c;
    w_co   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_last = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          r_sum  <= {w_s, r_sum[WIDTH-1:1]};
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_c    <= w_co;
          r_cout <= w_co;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
            // On the MSB step the carry flop holds the carry into the MSB.
            r_ovf   <= r_c ^ w_co;
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl (WIDTH=8).
// Directed vectors plus randomized operations, checked against an arithmetic
// reference model (a + b + cin in WIDTH+1 bits, signed overflow by sign rule).
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int unsigned n_chk;
  int unsigned n_pass;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADD_OVF_EN
    ,.ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one addition with start pulsed for a single accept edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    logic [W:0]   full;
    logic         exp_ovf;
    int           nbusy;
    int           ndone;
    int           dpos;
    logic [W-1:0] s_done;
    logic         c_done;
    logic         o_done;
    full    = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    exp_ovf = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    nbusy = 0; ndone = 0; dpos = -1;
    s_done = '0; c_done = 1'b0; o_done = 1'b0;
    // k indexes the negedge following edge E0+k.
    for (int k = 0; k <= int'(W) + 1; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        dpos   = k;
        s_done = sum;
        c_done = cout;
`ifdef SERIAL_ADD_OVF_EN
        o_done = ovf;
`endif
      end
    end
    check("busy_cycles", 64'(nbusy), 64'(W));
    check("done_pulses", 64'(ndone), 64'd1);
    check("done_pos", 64'(dpos), 64'(W));
    check("sum", 64'(s_done), 64'(full[W-1:0]));
    check("cout", 64'(c_done), 64'(full[W]));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 64'(o_done), 64'(exp_ovf));
`else
    o_done = exp_ovf;
`endif
    repeat (2) @(negedge clk);
    check("sum_held", 64'(sum), 64'(full[W-1:0]));
    check("cout_held", 64'(cout), 64'(full[W]));
  endtask

  initial begin
    int ndone;
    int k;
    n_chk = 0; n_pass = 0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Directed vectors.
    run_op(8'h3C, 8'h21, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1);
    run_op(8'hAA, 8'h55, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);

    // start held high; operands changed mid-shift; re-accept at E0+W+2.
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h10; cin = 1'b0;
    @(posedge clk);
    for (k = 0; k <= int'(W) + 2; k++) begin
      @(negedge clk);
      if (k == 3) begin a = 8'hFF; b = 8'hFF; end
      if (k == int'(W)) begin
        check("held_done", 64'(done), 64'd1);
        check("held_sum", 64'(sum), 64'h20);
      end
      if (k == int'(W) + 1) check("held_idle_busy", 64'(busy), 64'd0);
      if (k == int'(W) + 2) check("held_reaccept", 64'(busy), 64'd1);
    end
    start = 1'b0;
    ndone = 0;
    for (k = 0; k < 3 * int'(W) && ndone == 0; k++) begin
      @(negedge clk);
      if (done) ndone = 1;
    end
    check("second_done", 64'(ndone), 64'd1);
    check("second_sum", 64'(sum), 64'hFE);
    check("second_cout", 64'(cout), 64'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of shifting.
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    #1 rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("no_done_after_rst", 64'(ndone), 64'd0);
    run_op(8'h01, 8'h01, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
